// File: rtl/phys_free_list.sv
// Physical register free list: circular FIFO of free preg numbers with show-ahead
// allocation, commit-time returns and head-pointer checkpoints for branch recovery.
module phys_free_list #(
    parameter  int NUM_PHYS = 64,
    parameter  int NUM_ARCH = 32,
    parameter  int NUM_CKPT = 4,
    localparam int DEPTH    = NUM_PHYS - NUM_ARCH,
    localparam int PREG_W   = $clog2(NUM_PHYS),
    localparam int PTR_W    = $clog2(DEPTH) + 1,
    localparam int CKPT_W   = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alloc_req,
    output logic              alloc_valid,
    output logic [PREG_W-1:0] alloc_preg,
    input  logic              ret_valid,
    input  logic [PREG_W-1:0] ret_preg,
    input  logic              ckpt_save,
    input  logic [CKPT_W-1:0] ckpt_save_id,
    input  logic              ckpt_restore,
    input  logic [CKPT_W-1:0] ckpt_restore_id,
    output logic [PTR_W-1:0]  free_count,
    output logic              empty,
    output logic              full,
    output logic              overflow_err
);

    localparam int IDX_W = PTR_W - 1;

    logic [PREG_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  ckpt_r [NUM_CKPT];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic              overflow_r;

    logic [IDX_W-1:0]  head_idx_s;
    logic [IDX_W-1:0]  tail_idx_s;
    logic [PTR_W-1:0]  count_s;
    logic              empty_s;
    logic              full_s;
    logic              grant_s;
    logic              accept_s;
    logic              drop_s;
    logic [PTR_W-1:0]  head_next_s;

    // Advance a {wrap, index} pointer; the index wraps at DEPTH-1 so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p[IDX_W-1:0] == IDX_W'(DEPTH - 1)) begin
            r = {~p[PTR_W-1], {IDX_W{1'b0}}};
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    assign head_idx_s = head_r[IDX_W-1:0];
    assign tail_idx_s = tail_r[IDX_W-1:0];

    // Occupancy from pointer distance; differing wrap bits mean the tail has lapped the array end.
    always_comb begin
        count_s = '0;
        if (head_r[PTR_W-1] == tail_r[PTR_W-1]) begin
            count_s = PTR_W'({1'b0, tail_idx_s}) - PTR_W'({1'b0, head_idx_s});
        end else begin
            count_s = PTR_W'(DEPTH) - PTR_W'({1'b0, head_idx_s}) + PTR_W'({1'b0, tail_idx_s});
        end
    end

    assign empty_s = (count_s == PTR_W'(0));
    assign full_s  = (count_s == PTR_W'(DEPTH));

    // Grant/accept decisions; a full list still takes a return when the head frees a slot this cycle.
    always_comb begin
        grant_s     = alloc_req && !empty_s && !ckpt_restore;
        accept_s    = ret_valid && (!full_s || grant_s);
        drop_s      = ret_valid && !accept_s;
        head_next_s = head_r;
        if (grant_s) begin
            head_next_s = ptr_inc(head_r);
        end else begin
            head_next_s = head_r;
        end
    end

    // Pointer, checkpoint and error-flag state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_r     <= '0;
            tail_r     <= {1'b1, {IDX_W{1'b0}}};
            overflow_r <= 1'b0;
            for (int i = 0; i < NUM_CKPT; i++) begin
                ckpt_r[i] <= '0;
            end
        end else begin
            if (ckpt_restore) begin
                head_r <= ckpt_r[ckpt_restore_id];
            end else begin
                head_r <= head_next_s;
            end
            if (ckpt_save && !ckpt_restore) begin
                ckpt_r[ckpt_save_id] <= head_next_s;
            end
            if (accept_s) begin
                tail_r <= ptr_inc(tail_r);
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Entry storage; reset seeds the pregs above the identity-mapped architectural set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= PREG_W'(NUM_ARCH + i);
            end
        end else if (accept_s) begin
            mem_r[tail_idx_s] <= ret_preg;
        end
    end

    assign alloc_valid  = !empty_s;
    assign alloc_preg   = mem_r[head_idx_s];
    assign free_count   = count_s;
    assign empty        = empty_s;
    assign full         = full_s;
    assign overflow_err = overflow_r;

endmodule

// File: tb/tb_phys_free_list.sv
// Self-checking bench for phys_free_list: directed scenarios plus a randomized run
// against an absolute-counter reference model of the free list.
module tb_phys_free_list;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       alloc_req = 1'b0;
    logic       alloc_valid;
    logic [5:0] alloc_preg;
    logic       ret_valid = 1'b0;
    logic [5:0] ret_preg = 6'd0;
    logic       ckpt_save = 1'b0;
    logic [1:0] ckpt_save_id = 2'd0;
    logic       ckpt_restore = 1'b0;
    logic [1:0] ckpt_restore_id = 2'd0;
    logic [5:0] free_count;
    logic       empty;
    logic       full;
    logic       overflow_err;

    int checks = 0;
    int errors = 0;

    phys_free_list #(.NUM_PHYS(64), .NUM_ARCH(32), .NUM_CKPT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .alloc_req(alloc_req), .alloc_valid(alloc_valid), .alloc_preg(alloc_preg),
        .ret_valid(ret_valid), .ret_preg(ret_preg),
        .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
        .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id),
        .free_count(free_count), .empty(empty), .full(full), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        alloc_req = 1'b0; ret_valid = 1'b0; ckpt_save = 1'b0; ckpt_restore = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL reset_count got %0d exp 32", free_count); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL reset_full got %0b exp 1", full); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL reset_empty got %0b exp 0", empty); end
        checks++; if (alloc_valid !== 1'b1) begin errors++; $display("FAIL reset_valid got %0b exp 1", alloc_valid); end
        checks++; if (alloc_preg !== 6'd32) begin errors++; $display("FAIL reset_preg got %0d exp 32", alloc_preg); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", overflow_err); end
    endtask

    task automatic test_alloc_seq();
        do_reset();
        alloc_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (alloc_preg !== 6'(32 + i)) begin errors++; $display("FAIL alloc_seq_preg%0d got %0d exp %0d", i, alloc_preg, 32 + i); end
            tick();
        end
        alloc_req = 1'b0;
        checks++; if (free_count !== 6'd29) begin errors++; $display("FAIL alloc_seq_count got %0d exp 29", free_count); end
    endtask

    task automatic test_empty();
        do_reset();
        alloc_req = 1'b1;
        for (int i = 0; i < 32; i++) tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL empty_flag got %0b exp 1", empty); end
        checks++; if (alloc_valid !== 1'b0) begin errors++; $display("FAIL empty_valid got %0b exp 0", alloc_valid); end
        tick();
        checks++; if (free_count !== 6'd0) begin errors++; $display("FAIL empty_extra_alloc got %0d exp 0", free_count); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL empty_no_err got %0b exp 0", overflow_err); end
        alloc_req = 1'b0; ret_valid = 1'b1; ret_preg = 6'd5;
        checks++; if (alloc_valid !== 1'b0) begin errors++; $display("FAIL empty_ret_same_cycle got %0b exp 0", alloc_valid); end
        tick();
        ret_valid = 1'b0;
        checks++; if (alloc_preg !== 6'd5) begin errors++; $display("FAIL empty_ret_preg got %0d exp 5", alloc_preg); end
        checks++; if (free_count !== 6'd1) begin errors++; $display("FAIL empty_ret_count got %0d exp 1", free_count); end
        checks++; if (alloc_valid !== 1'b1) begin errors++; $display("FAIL empty_ret_valid got %0b exp 1", alloc_valid); end
    endtask

    task automatic test_ckpt();
        do_reset();
        alloc_req = 1'b1;
        tick(); tick();
        ckpt_save = 1'b1; ckpt_save_id = 2'd1;
        tick();
        ckpt_save = 1'b0;
        tick(); tick(); tick();
        checks++; if (alloc_preg !== 6'd38) begin errors++; $display("FAIL ckpt_before_restore got %0d exp 38", alloc_preg); end
        // alloc_req stays high: restore cycle must not grant
        ckpt_restore = 1'b1; ckpt_restore_id = 2'd1;
        ckpt_save = 1'b1; ckpt_save_id = 2'd2;
        tick();
        ckpt_restore = 1'b0; ckpt_save = 1'b0; alloc_req = 1'b0;
        checks++; if (alloc_preg !== 6'd35) begin errors++; $display("FAIL ckpt_restore_preg got %0d exp 35", alloc_preg); end
        checks++; if (free_count !== 6'd29) begin errors++; $display("FAIL ckpt_restore_count got %0d exp 29", free_count); end
        // slot 2 save was ignored, so it still holds its reset value 0
        ckpt_restore = 1'b1; ckpt_restore_id = 2'd2;
        tick();
        ckpt_restore = 1'b0;
        checks++; if (alloc_preg !== 6'd32) begin errors++; $display("FAIL ckpt_unwritten_preg got %0d exp 32", alloc_preg); end
        checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL ckpt_unwritten_count got %0d exp 32", free_count); end
    endtask

    task automatic test_overflow();
        do_reset();
        ret_valid = 1'b1; ret_preg = 6'd7;
        tick();
        ret_valid = 1'b0;
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b exp 1", overflow_err); end
        checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL ovf_count got %0d exp 32", free_count); end
        tick();
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", overflow_err); end
        ret_valid = 1'b1; ret_preg = 6'd7; alloc_req = 1'b1;
        tick();
        ret_valid = 1'b0; alloc_req = 1'b0;
        checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL ovf_swap_count got %0d exp 32", free_count); end
        checks++; if (alloc_preg !== 6'd33) begin errors++; $display("FAIL ovf_swap_preg got %0d exp 33", alloc_preg); end
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_swap_flag got %0b exp 1", overflow_err); end
        do_reset();
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b exp 0", overflow_err); end
    endtask

    task automatic test_async_reset();
        do_reset();
        alloc_req = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (free_count !== 6'd22) begin errors++; $display("FAIL areset_pre got %0d exp 22", free_count); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL areset_count got %0d exp 32", free_count); end
        checks++; if (alloc_preg !== 6'd32) begin errors++; $display("FAIL areset_preg got %0d exp 32", alloc_preg); end
        checks++; if ({full, empty, alloc_valid, overflow_err} !== 4'b1010) begin
            errors++; $display("FAIL areset_flags got %b exp 1010", {full, empty, alloc_valid, overflow_err});
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        alloc_req = 1'b0;
        checks++; if (alloc_preg !== 6'd33) begin errors++; $display("FAIL areset_first_edge got %0d exp 33", alloc_preg); end
    endtask

    // Reference model: absolute head/tail counters over a ring of 32 slots.
    task automatic test_random();
        int  m_mem [32];
        int  ck [4];
        bit  ckv [4];
        int  hc, tc, fc, id;
        bit  m_ovf, ar, rv, cs, cr, gr, acc;
        int  bias;
        logic [5:0] rp;
        logic [1:0] csid;
        do_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 32 + i;
        for (int i = 0; i < 4; i++) begin ck[i] = 0; ckv[i] = 1'b0; end
        hc = 0; tc = 32; m_ovf = 1'b0;
        for (int n = 0; n < 1200; n++) begin
            fc = tc - hc;
            checks++; if (free_count !== 6'(fc)) begin errors++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", n, free_count, fc); end
            checks++; if (empty !== (fc == 0) || full !== (fc == 32) || alloc_valid !== (fc != 0)) begin
                errors++; $display("FAIL rnd_flags cyc %0d got e%0b f%0b v%0b fc %0d", n, empty, full, alloc_valid, fc);
            end
            checks++; if (overflow_err !== m_ovf) begin errors++; $display("FAIL rnd_ovf cyc %0d got %0b exp %0b", n, overflow_err, m_ovf); end
            if (fc != 0) begin
                checks++;
                if (alloc_preg !== 6'(m_mem[hc % 32])) begin
                    errors++; $display("FAIL rnd_preg cyc %0d got %0d exp %0d", n, alloc_preg, m_mem[hc % 32]);
                end
            end
            bias = ((n / 150) % 2 == 0) ? 75 : 25;
            ar   = ($urandom_range(0, 99) < bias);
            rv   = ($urandom_range(0, 99) < (100 - bias));
            rp   = 6'($urandom_range(0, 63));
            cs   = ($urandom_range(0, 99) < 12);
            csid = 2'($urandom_range(0, 3));
            cr   = 1'b0;
            id   = $urandom_range(0, 3);
            if ($urandom_range(0, 99) < 8 && ckv[id]) begin
                acc = rv && (fc != 32);
                if (tc + int'(acc) - ck[id] <= 32) cr = 1'b1;
            end
            gr  = ar && (fc != 0) && !cr;
            acc = rv && ((fc != 32) || gr);
            alloc_req = ar; ret_valid = rv; ret_preg = rp;
            ckpt_save = cs; ckpt_save_id = csid;
            ckpt_restore = cr; ckpt_restore_id = 2'(id);
            tick();
            if (rv && !acc) m_ovf = 1'b1;
            if (acc) begin m_mem[tc % 32] = int'(rp); tc++; end
            if (gr) hc++;
            if (cs && !cr) begin ck[csid] = hc; ckv[csid] = 1'b1; end
            if (cr) hc = ck[id];
        end
        alloc_req = 1'b0; ret_valid = 1'b0; ckpt_save = 1'b0; ckpt_restore = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alloc_seq();
        test_empty();
        test_ckpt();
        test_overflow();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
